// File: rtl/uart_pkg.sv
// Shared constants and types for the UART decimal command parser.
package uart_pkg;

  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] ESC    = 8'h1B;
  localparam logic [7:0] DIGIT0 = 8'h30;
  localparam logic [7:0] DIGIT9 = 8'h39;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BADCHAR  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TOOLONG  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2
  } parser_state_t;

  typedef enum logic [1:0] {
    BC_DIGIT = 2'd0,
    BC_TERM  = 2'd1,
    BC_ABORT = 2'd2,
    BC_OTHER = 2'd3
  } byte_class_t;

  function automatic byte_class_t classify(input logic [7:0] b);
    byte_class_t cls;
    if ((b >= DIGIT0) && (b <= DIGIT9)) begin
      cls = BC_DIGIT;
    end else if ((b == CR) || (b == LF)) begin
      cls = BC_TERM;
    end else if (b == ESC) begin
      cls = BC_ABORT;
    end else begin
      cls = BC_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/dec_mac.sv
// Combinational decimal multiply-accumulate: acc*10 + digit with overflow flag.
module dec_mac #(
  parameter int VALUE_W = 16
) (
  input  logic [VALUE_W-1:0] acc,
  input  logic [3:0]         digit,
  output logic [VALUE_W-1:0] result,
  output logic               overflow
);

  // Four guard bits are enough: acc*10+9 < 16*2^VALUE_W.
  logic [VALUE_W+3:0] acc_ext_s;
  logic [VALUE_W+3:0] wide_s;

  assign acc_ext_s = {4'b0000, acc};
  assign wide_s    = (acc_ext_s << 3) + (acc_ext_s << 1) + (VALUE_W+4)'(digit);
  assign result    = wide_s[VALUE_W-1:0];
  assign overflow  = |wide_s[VALUE_W+3:VALUE_W];

endmodule

// File: rtl/uart_dec_parser.sv
// Decimal command parser: accumulates ASCII digits and reports a value or an error on CR/LF.
module uart_dec_parser
  import uart_pkg::*;
#(
  parameter int VALUE_W    = 16,
  parameter int MAX_DIGITS = 5,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               out_valid,
  output logic [VALUE_W-1:0] out_value,
  output logic [CNT_W-1:0]   out_digits,
  output logic               err,
  output logic [1:0]         err_code,
  output logic               busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  parser_state_t      state_r, state_n;
  logic [VALUE_W-1:0] acc_r, acc_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic [1:0]         pend_r, pend_n;
  logic               emit_val_s;
  logic               emit_err_s;
  byte_class_t        cls_s;
  logic [VALUE_W-1:0] mac_result_s;
  logic               mac_ovf_s;

  dec_mac #(.VALUE_W(VALUE_W)) u_mac (
    .acc      (acc_r),
    .digit    (in_data[3:0]),
    .result   (mac_result_s),
    .overflow (mac_ovf_s)
  );

  assign cls_s = classify(in_data);

  // Next-state, accumulator and pulse-request logic.
  always_comb begin
    state_n    = state_r;
    acc_n      = acc_r;
    cnt_n      = cnt_r;
    pend_n     = pend_r;
    emit_val_s = 1'b0;
    emit_err_s = 1'b0;
    if (in_valid) begin
      case (state_r)
        ST_IDLE: begin
          case (cls_s)
            BC_DIGIT: begin
              acc_n   = VALUE_W'(in_data[3:0]);
              cnt_n   = ONE_CNT;
              state_n = ST_ACCUM;
            end
            BC_OTHER: begin
              pend_n  = ERR_BADCHAR;
              state_n = ST_DISCARD;
            end
            default: begin
              state_n = ST_IDLE;
            end
          endcase
        end
        ST_ACCUM: begin
          case (cls_s)
            BC_DIGIT: begin
              if (cnt_r == MAX_CNT) begin
                pend_n  = ERR_TOOLONG;
                state_n = ST_DISCARD;
              end else if (mac_ovf_s) begin
                pend_n  = ERR_OVERFLOW;
                state_n = ST_DISCARD;
              end else begin
                acc_n = mac_result_s;
                cnt_n = cnt_r + ONE_CNT;
              end
            end
            BC_TERM: begin
              emit_val_s = 1'b1;
              state_n    = ST_IDLE;
            end
            BC_ABORT: begin
              state_n = ST_IDLE;
            end
            default: begin
              pend_n  = ERR_BADCHAR;
              state_n = ST_DISCARD;
            end
          endcase
        end
        ST_DISCARD: begin
          case (cls_s)
            BC_TERM: begin
              emit_err_s = 1'b1;
              state_n    = ST_IDLE;
            end
            BC_ABORT: begin
              state_n = ST_IDLE;
            end
            default: begin
              state_n = ST_DISCARD;
            end
          endcase
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
      // Every frame starts from a clean accumulator.
      if (state_n == ST_IDLE) begin
        acc_n  = {VALUE_W{1'b0}};
        cnt_n  = {CNT_W{1'b0}};
        pend_n = ERR_NONE;
      end else begin
        pend_n = pend_n;
      end
    end else begin
      state_n = state_r;
    end
  end

  // Parser state and frame accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      acc_r   <= {VALUE_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      pend_r  <= ERR_NONE;
    end else begin
      state_r <= state_n;
      acc_r   <= acc_n;
      cnt_r   <= cnt_n;
      pend_r  <= pend_n;
    end
  end

  // Registered outputs; result and error registers hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      out_value  <= {VALUE_W{1'b0}};
      out_digits <= {CNT_W{1'b0}};
      err_code   <= ERR_NONE;
    end else begin
      out_valid <= emit_val_s;
      err       <= emit_err_s;
      busy      <= (state_n != ST_IDLE);
      if (emit_val_s) begin
        out_value  <= acc_r;
        out_digits <= cnt_r;
      end
      if (emit_err_s) begin
        err_code <= pend_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_dec_parser.sv
// Self-checking bench: directed test-plan frames plus random frames against a frame-level model.
module tb_uart_dec_parser;

  localparam int VALUE_W    = 16;
  localparam int MAX_DIGITS = 5;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam int MAXV       = (1 << VALUE_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [7:0]         in_data = 8'h00;
  logic               out_valid;
  logic [VALUE_W-1:0] out_value;
  logic [CNT_W-1:0]   out_digits;
  logic               err;
  logic [1:0]         err_code;
  logic               busy;

  int errors = 0;
  int checks = 0;

  // Reference model: frame-level view with integer arithmetic.
  bit m_open;
  int m_code;
  int m_val;
  int m_nd;
  int e_value;
  int e_digits;
  int e_code;
  bit e_valid;
  bit e_err;

  uart_dec_parser #(.VALUE_W(VALUE_W), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_value  (out_value),
    .out_digits (out_digits),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 1'b0; m_code = 0; m_val = 0; m_nd = 0;
    e_value = 0; e_digits = 0; e_code = 0; e_valid = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] b);
    bit is_digit;
    bit is_term;
    bit is_esc;
    int d;
    is_digit = (b >= 8'h30) && (b <= 8'h39);
    is_term  = (b == 8'h0D) || (b == 8'h0A);
    is_esc   = (b == 8'h1B);
    d        = int'(b) - 48;
    e_valid  = 1'b0;
    e_err    = 1'b0;
    if (!m_open) begin
      if (is_digit) begin
        m_open = 1'b1; m_code = 0; m_val = d; m_nd = 1;
      end else if (!is_term && !is_esc) begin
        m_open = 1'b1; m_code = 1;
      end
    end else if (m_code != 0) begin
      if (is_term) begin
        e_err = 1'b1; e_code = m_code; m_open = 1'b0;
      end else if (is_esc) begin
        m_open = 1'b0;
      end
    end else begin
      if (is_digit) begin
        if (m_nd == MAX_DIGITS) m_code = 3;
        else if (m_val * 10 + d > MAXV) m_code = 2;
        else begin
          m_val = m_val * 10 + d; m_nd++;
        end
      end else if (is_term) begin
        e_valid = 1'b1; e_value = m_val; e_digits = m_nd; m_open = 1'b0;
      end else if (is_esc) begin
        m_open = 1'b0;
      end else begin
        m_code = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), int'(e_valid));
    chk({tag, ".err"}, int'(err), int'(e_err));
    chk({tag, ".busy"}, int'(busy), int'(m_open));
    chk({tag, ".out_value"}, int'(out_value), e_value);
    chk({tag, ".out_digits"}, int'(out_digits), e_digits);
    chk({tag, ".err_code"}, int'(err_code), e_code);
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic send(input logic [7:0] b, input string tag);
    in_valid = 1'b1;
    in_data  = b;
    model_step(b);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    e_valid = 1'b0;
    e_err   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all(tag);
    end
  endtask

  task automatic send_str(input string s, input int gap, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], tag);
      idle(gap, tag);
    end
  endtask

  task automatic send_num(input int v, input int gap, input string tag);
    int digs[$];
    int t;
    t = v;
    do begin
      digs.push_front(t % 10);
      t = t / 10;
    end while (t > 0);
    foreach (digs[i]) begin
      send(8'(48 + digs[i]), tag);
      idle(gap, tag);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_all("after_reset");

    send_str("1234\015", 1, "t1234");
    chk("t1234.value_hex", int'(out_value), 32'h04D2);
    send_str("42\015\012", 0, "t42");
    send_str("\015", 2, "t42_lone_cr");
    send_str("65535\012", 0, "tmax");
    chk("tmax.value", int'(out_value), 65535);
    send_str("65536\012", 1, "tovf");
    chk("tovf.code", int'(err_code), 2);
    send_str("12a3\015", 0, "tbad");
    send_str("000123\015", 1, "tlong");
    chk("tlong.code", int'(err_code), 3);
    send_str("7\015", 0, "t7");
    send_str("00000\015", 0, "tzero5");
    chk("tzero5.digits", int'(out_digits), 5);
    send_str("000000\015", 0, "tzero6");
    send_str("98\0335\015", 1, "tesc");
    send_str("x\033\015", 0, "tdisc_esc");

    send_str("98", 0, "trst_pre");
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_reset");
    @(negedge clk);
    check_all("mid_reset_hold");
    rst = 1'b0;
    send_str("7\015", 0, "trst_post");
    chk("trst_post.value", int'(out_value), 7);

    for (int f = 0; f < 300; f++) begin
      int n;
      int gap;
      int r;
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) begin
        send_num(int'($urandom_range(65525, 65545)), gap, "rnd_edge");
      end else begin
        n = int'($urandom_range(1, 7));
        for (int i = 0; i < n; i++) begin
          r = int'($urandom_range(0, 99));
          if (r < 85)      send(8'(48 + $urandom_range(0, 9)), "rnd");
          else if (r < 91) send(8'(97 + $urandom_range(0, 25)), "rnd");
          else if (r < 95) send(8'h1B, "rnd");
          else             send(8'h0A, "rnd");
          idle(gap, "rnd_gap");
        end
      end
      send(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A, "rnd_term");
      if ($urandom_range(0, 3) == 0) send(8'h0A, "rnd_extra_lf");
      idle(gap, "rnd_tail");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_dec_parser.md
# uart_dec_parser

Decimal command parser downstream of the UART receiver. Consumes the received byte stream as `in_valid`/`in_data` pulses, one byte per pulse. Accumulates ASCII decimal digits into an unsigned binary value. On a CR or LF terminator it emits either the value or an error code. It drives the numeric/display logic that follows the receiver.

## Interface
- `VALUE_W`, default 16: width of the result; the legal range is 0 to 2^VALUE_W−1.
- `MAX_DIGITS`, default 5: maximum digits per number; leading zeros count.
- `clk`  in  1  single system clock, all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state and outputs.
- `in_valid`  in  1  one-cycle strobe: `in_data` holds a received byte.
- `in_data`  in  8  received byte; sampled only when `in_valid`=1.
- `out_valid`  out  1  one-cycle pulse: `out_value`/`out_digits` updated with a new result.
- `out_value`  out  VALUE_W  last good result; holds until the next good result.
- `out_digits`  out  $clog2(MAX_DIGITS+1)  digit count of the last good result.
- `err`  out  1  one-cycle pulse: a frame was terminated in error.
- `err_code`  out  2  1=BADCHAR, 2=OVERFLOW, 3=TOOLONG; holds until the next `err`.
- `busy`  out  1  high while a frame is open (state ≠ IDLE).

## Operation
- **Byte classes:**
  - DIGIT: 0x30–0x39.
  - TERM: 0x0D or 0x0A.
  - ABORT: 0x1B.
  - Anything else is OTHER.
- **States:** IDLE, ACCUM, DISCARD.
- **IDLE:**
  - DIGIT → acc=d, cnt=1, go to ACCUM.
  - TERM → ignored, so CR LF yields one result.
  - ABORT → ignored.
  - OTHER → latch pending code BADCHAR, go to DISCARD.
- **ACCUM:**
  - DIGIT with cnt=MAX_DIGITS → pending TOOLONG, go to DISCARD.
  - Otherwise DIGIT → compute acc*10+d at VALUE_W+4 bits.
    - Result > 2^VALUE_W−1 → pending OVERFLOW, go to DISCARD.
    - Else acc updated, cnt+1.
  - TERM → `out_value`=acc, `out_digits`=cnt, pulse `out_valid`, go to IDLE.
  - ABORT → go to IDLE, no output.
  - OTHER → pending BADCHAR, go to DISCARD.
- **DISCARD:**
  - All bytes ignored; the first error latched wins.
  - TERM → `err_code`=pending, pulse `err`, go to IDLE.
  - ABORT → go to IDLE silently.
- `acc` and `cnt` are cleared whenever the block enters IDLE.
- `out_valid` and `err` are never high in the same cycle.

## Timing
- Reset values: state=IDLE; acc, cnt, `out_value`, `out_digits`, `err_code` = 0; `out_valid`, `err`, `busy` = 0.
- **Latency:** the `out_valid`/`err` pulse appears exactly one cycle after the clock edge that samples the TERM byte. Pulse width is exactly 1 cycle.
- **Throughput:** back-to-back `in_valid` on every cycle is accepted with no stall. There is no backpressure; the block is always ready.
- `busy` rises the cycle after the first byte of a frame is accepted. It falls in the same cycle that the result or error pulse is asserted.
- Reset asserted mid-frame: the frame is dropped immediately, no pulse is emitted, and the result/error registers are cleared.
- A TERM arriving the cycle after a result pulse is handled normally; in IDLE it is ignored.
- **Boundary values** (defaults):
  - "65535" is legal.
  - "65536" gives OVERFLOW.
  - "00000" gives 0 with 5 digits.
  - "000000" gives TOOLONG.

## Structure
- Shared package `uart_pkg` holds:
  - ASCII constants: CR, LF, ESC, DIGIT0, DIGIT9.
  - Error-code constants: ERR_NONE/BADCHAR/OVERFLOW/TOOLONG.
  - The parser-state typedef.
- One sub-module is natural: `dec_mac`.
  - Purely combinational.
  - Inputs acc and digit; outputs acc*10+d computed as (acc<<3)+(acc<<1)+d, plus an overflow flag.
- The top level holds the FSM, counters and output registers.

## Test plan
- "1234\r" → one `out_valid` pulse one cycle after '\r'; `out_value`=1234 (0x04D2), `out_digits`=4, `err` stays 0.
- "42\r\n" then "\r" → exactly one `out_valid`, value 42. The second '\n' and the lone '\r' produce no pulse and `busy` stays 0.
- "65535\n" → value 65535. Then "65536\n" → `err` pulse with `err_code`=2, no `out_valid`, and `out_value` stays 65535.
- "12a3\r" → `err`, code 1. Then "000123\r" → `err`, code 3. Then "7\r" → `out_valid`, value 7, digits 1.
- "98" then ESC, then "5\r" → no pulse for the aborted frame; then value 5.
- "98", then `rst` for 1 cycle, then "7\r" → every output is 0 during reset; afterwards value 7, digits 1.
- Bytes driven on consecutive cycles → same results as with gapped strobes.
